// File: rtl/btn_evt_pkg.sv
// Shared constants for the button event queue.
// Register map, event word layout and button codes.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        REG_LEVEL  = 2'd0,
        REG_STATUS = 2'd1,
        REG_EVENT  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam int EVT_VALID_BIT  = 31;
    localparam int STATUS_OVF_BIT = 8;

    localparam logic BTN1 = 1'b0;
    localparam logic BTN2 = 1'b1;

    function automatic logic [31:0] evt_word(input logic code);
        logic [31:0] w;
        w = 32'h0;
        w[EVT_VALID_BIT] = 1'b1;
        w[0] = code;
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one
// active-low button; pulses press_o on each accepted press.
module btn_debounce #(
    parameter int CNT_W           = 22,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic db_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    assign accept  = (s2_q != db_q) && (cnt_q == LAST);
    assign press_o = accept && !s2_q;
    assign db_o    = db_q;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q + 1'b1;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (accept) begin
            db_d  = s2_q;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            db_q  <= 1'b1;
            cnt_q <= '0;
        end else begin
            s1_q  <= btn_ni;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_queue.sv
// Debounced two-button press queue with a memory-mapped read port.
// Presses are latched as pending, pushed one per cycle into a FIFO.
module button_event_queue
    import btn_evt_pkg::*;
#(
    parameter int CNT_W           = 22,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn1_n,
    input  logic        btn2_n,
    input  logic        ren,
    input  logic [31:0] address,
    output logic [31:0] data_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [1:0]            db;
    logic [1:0]            press;
    logic [1:0]            pend_q;
    logic [1:0]            pend_d;
    logic [1:0]            pend_clr;
    logic [FIFO_DEPTH-1:0] mem_q;
    logic [AW-1:0]         wr_q;
    logic [AW-1:0]         rd_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic [31:0]           data_q;
    logic [31:0]           data_d;
    logic [31:0]           cnt_ext;
    reg_sel_e              sel;
    logic                  push_vld;
    logic                  push_code;
    logic                  push_ok;
    logic                  ovf_evt;
    logic                  pop;
    logic                  unused_addr;

    btn_debounce #(
        .CNT_W          (CNT_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_ni (btn1_n),
        .db_o   (db[0]),
        .press_o(press[0])
    );

    btn_debounce #(
        .CNT_W          (CNT_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_ni (btn2_n),
        .db_o   (db[1]),
        .press_o(press[1])
    );

    assign sel         = reg_sel_e'(address[3:2]);
    assign unused_addr = ^{address[31:4], address[1:0]};
    assign cnt_ext     = 32'(count_q);
    assign data_out    = data_q;

    // btn1 wins the push slot; btn2 stays pending one more cycle
    always_comb begin
        push_vld  = |pend_q;
        push_code = pend_q[0] ? BTN1 : BTN2;
        pend_clr  = pend_q[0] ? 2'b01 : pend_q & 2'b10;
        push_ok   = push_vld && (count_q != FULL);
        ovf_evt   = push_vld && (count_q == FULL);
        pend_d    = (pend_q & ~pend_clr) | press;
        pop       = ren && (sel == REG_EVENT) && (count_q != '0);
    end

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ren && (sel == REG_STATUS)) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;
    end

    always_comb begin
        data_d = data_q;
        if (ren) begin
            data_d = 32'h0;
            unique case (sel)
                REG_LEVEL: data_d[1:0] = ~db;
                REG_STATUS: begin
                    data_d[STATUS_OVF_BIT] = ovf_q;
                    data_d[2:0]            = cnt_ext[2:0];
                end
                REG_EVENT: begin
                    if (count_q != '0) data_d = evt_word(mem_q[rd_q]);
                end
                default: data_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            if (push_ok) begin
                mem_q[wr_q] <= push_code;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with a 16-cycle debounce
// and a 4-entry queue; every read is compared to a fixed value.
module tb_button_event_queue;

    localparam logic [31:0] A_LEVEL  = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_EVENT  = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic        clk;
    logic        rst_n;
    logic        btn1_n;
    logic        btn2_n;
    logic        ren;
    logic [31:0] address;
    logic [31:0] data_out;
    logic [31:0] rd;
    int          n_chk;
    int          n_err;

    button_event_queue #(
        .CNT_W          (22),
        .DEBOUNCE_CYCLES(16),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn1_n  (btn1_n),
        .btn2_n  (btn2_n),
        .ren     (ren),
        .address (address),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // call at a negedge; returns data sampled one negedge later
    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        ren     = 1'b1;
        address = a;
        @(negedge clk);
        ren     = 1'b0;
        address = 32'h0;
        d       = data_out;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        if (b == 1) btn1_n = 1'b0;
        else        btn2_n = 1'b0;
        wait_n(30);
        btn1_n = 1'b1;
        btn2_n = 1'b1;
        wait_n(30);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        btn1_n  = 1'b1;
        btn2_n  = 1'b1;
        ren     = 1'b0;
        address = 32'h0;
        wait_n(3);
        chk("rst_dout", data_out, 32'h0);
        rst_n = 1'b1;
        wait_n(2);
        rd_reg(A_LEVEL, rd);  chk("rst_level", rd, 32'h0);
        rd_reg(A_STATUS, rd); chk("rst_status", rd, 32'h0);
        rd_reg(A_EVENT, rd);  chk("rst_event", rd, 32'h0);

        // 1: held press
        btn1_n = 1'b0;
        wait_n(40);
        rd_reg(A_LEVEL, rd);  chk("t1_level", rd, 32'h1);
        btn1_n = 1'b1;
        wait_n(30);
        rd_reg(A_EVENT, rd);  chk("t1_ev0", rd, 32'h8000_0000);
        wait_n(3);
        chk("t1_hold", data_out, 32'h8000_0000);
        rd_reg(A_EVENT, rd);  chk("t1_empty", rd, 32'h0);

        // 2: short pulse and bounce
        btn2_n = 1'b0;
        wait_n(10);
        btn2_n = 1'b1;
        wait_n(5);
        btn2_n = 1'b0;
        wait_n(3);
        btn2_n = 1'b1;
        wait_n(2);
        rd_reg(A_LEVEL, rd);  chk("t2_level", rd, 32'h0);
        wait_n(30);
        rd_reg(A_STATUS, rd); chk("t2_status", rd, 32'h0);

        // 3: simultaneous press
        btn1_n = 1'b0;
        btn2_n = 1'b0;
        wait_n(30);
        rd_reg(A_LEVEL, rd);  chk("t3_level", rd, 32'h3);
        btn1_n = 1'b1;
        btn2_n = 1'b1;
        wait_n(30);
        rd_reg(A_EVENT, rd);  chk("t3_ev0", rd, 32'h8000_0000);
        rd_reg(A_EVENT, rd);  chk("t3_ev1", rd, 32'h8000_0001);
        rd_reg(A_EVENT, rd);  chk("t3_empty", rd, 32'h0);
        rd_reg(A_RSVD, rd);   chk("t3_rsvd", rd, 32'h0);

        // 4: overflow
        for (int i = 0; i < 6; i++) press(1);
        rd_reg(A_STATUS, rd); chk("t4_ovf", rd, 32'h0000_0104);
        rd_reg(A_STATUS, rd); chk("t4_clr", rd, 32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            rd_reg(A_EVENT, rd);
            chk($sformatf("t4_ev%0d", i), rd, 32'h8000_0000);
        end
        rd_reg(A_STATUS, rd); chk("t4_drained", rd, 32'h0);

        // 5: push lands on the pop edge (19 edges after drive)
        press(2);
        rd_reg(A_STATUS, rd); chk("t5_pre", rd, 32'h1);
        btn1_n = 1'b0;
        wait_n(18);
        rd_reg(A_EVENT, rd);  chk("t5_pop", rd, 32'h8000_0001);
        rd_reg(A_STATUS, rd); chk("t5_cnt", rd, 32'h1);
        rd_reg(A_EVENT, rd);  chk("t5_new", rd, 32'h8000_0000);
        btn1_n = 1'b1;
        wait_n(30);

        // 6: reset mid-debounce with two queued events
        press(2);
        press(2);
        rd_reg(A_STATUS, rd); chk("t6_pre", rd, 32'h2);
        btn1_n = 1'b0;
        wait_n(8);
        rst_n = 1'b0;
        wait_n(1);
        chk("t6_dout", data_out, 32'h0);
        rst_n = 1'b1;
        rd_reg(A_STATUS, rd); chk("t6_status", rd, 32'h0);
        rd_reg(A_LEVEL, rd);  chk("t6_level", rd, 32'h0);
        rd_reg(A_EVENT, rd);  chk("t6_event", rd, 32'h0);
        btn1_n = 1'b1;
        wait_n(30);
        rd_reg(A_STATUS, rd); chk("t6_after", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
